mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 11 +
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef enum logic {OWN_FETCH = 1'b0, OWN_EXEC = 1'b1} owner_t;

  localparam int RD_LAT_DEF     = 1;
  localparam int STARVE_MAX_DEF = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises fetch (read-only) and exec (read/write) accesses onto the single
// memory port, one outstanding transaction at a time, with fetch anti-starvation.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       f_req,
  input  logic [7:0] f_addr,
  output logic       f_ack,
  output logic       f_done,
  output logic [7:0] f_rdata,
  input  logic       x_req,
  input  logic       x_we,
  input  logic [7:0] x_addr,
  input  logic [7:0] x_wdata,
  output logic       x_ack,
  output logic       x_done,
  output logic [7:0] x_rdata,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data_out,
  output logic       mem_we,
  input  logic [7:0] mem_data_in,
  output logic       busy
);

  state_t     state;
  owner_t     owner;
  logic       xact_wr;
  logic       cancel;
  logic [3:0] starve_cnt;
  logic [2:0] wait_cnt;

  logic f_elig, fetch_wins, fetch_kill, cap;

  always_comb begin
    f_elig     = f_req && !flush;
    fetch_wins = f_elig && (!x_req || starve_cnt == 4'(STARVE_MAX));
    // a flush landing in the capture or done cycle itself must also suppress
    fetch_kill = cancel || flush;
    cap        = (state == ISSUE && !xact_wr && RD_LAT == 1) ||
                 (state == WAIT && wait_cnt == 3'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      owner        <= OWN_FETCH;
      xact_wr      <= 1'b0;
      cancel       <= 1'b0;
      starve_cnt   <= '0;
      wait_cnt     <= '0;
      f_ack        <= 1'b0;
      f_done       <= 1'b0;
      f_rdata      <= '0;
      x_ack        <= 1'b0;
      x_done       <= 1'b0;
      x_rdata      <= '0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      mem_we       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      f_ack  <= 1'b0;
      x_ack  <= 1'b0;
      f_done <= 1'b0;
      x_done <= 1'b0;

      if (state != IDLE && owner == OWN_FETCH && flush) cancel <= 1'b1;

      if (cap) begin
        if (owner == OWN_EXEC)  x_rdata <= mem_data_in;
        else if (!fetch_kill)   f_rdata <= mem_data_in;
      end

      case (state)
        IDLE: begin
          cancel <= 1'b0;
          if (fetch_wins) begin
            owner        <= OWN_FETCH;
            xact_wr      <= 1'b0;
            mem_addr     <= f_addr;
            mem_data_out <= '0;
            mem_we       <= 1'b0;
            f_ack        <= 1'b1;
            starve_cnt   <= '0;
            busy         <= 1'b1;
            state        <= ISSUE;
          end else if (x_req) begin
            owner        <= OWN_EXEC;
            xact_wr      <= x_we;
            mem_addr     <= x_addr;
            mem_data_out <= x_wdata;
            mem_we       <= x_we;
            x_ack        <= 1'b1;
            busy         <= 1'b1;
            state        <= ISSUE;
            // exec only beats an eligible fetch below the limit, so no overflow
            if (f_elig) starve_cnt <= starve_cnt + 4'd1;
          end
        end
        ISSUE: begin
          mem_we <= 1'b0;
          if (xact_wr || RD_LAT == 1) begin
            state <= RESP;
          end else begin
            wait_cnt <= 3'(RD_LAT - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 3'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 3'd1;
        end
        RESP: begin
          if (owner == OWN_EXEC) x_done <= 1'b1;
          else                   f_done <= !fetch_kill;
          cancel <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT=1 and RD_LAT=3) against a shared memory image.
module tb_mem_port_arbiter;

  localparam int EV_FACK = 0, EV_XACK = 1, EV_FDONE = 2, EV_XDONE = 3, EV_WE = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] data;
  } ev_t;

  ev_t q0[$];
  ev_t q1[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  mon_en = 0;
  logic [7:0] mem [256];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // dut a: RD_LAT=1
  logic       a_rst, a_flush, a_f_req, a_x_req, a_x_we;
  logic [7:0] a_f_addr, a_x_addr, a_x_wdata, a_mem_data_in;
  logic       a_f_ack, a_f_done, a_x_ack, a_x_done, a_mem_we, a_busy;
  logic [7:0] a_f_rdata, a_x_rdata, a_mem_addr, a_mem_data_out;
  // dut b: RD_LAT=3
  logic       b_rst, b_flush, b_f_req, b_x_req, b_x_we;
  logic [7:0] b_f_addr, b_x_addr, b_x_wdata, b_mem_data_in;
  logic       b_f_ack, b_f_done, b_x_ack, b_x_done, b_mem_we, b_busy;
  logic [7:0] b_f_rdata, b_x_rdata, b_mem_addr, b_mem_data_out;

  // memory output follows the held address; the arbiter samples it at its own latency
  always_comb a_mem_data_in = mem[a_mem_addr];
  always_comb b_mem_data_in = mem[b_mem_addr];

  mem_port_arbiter #(.RD_LAT(1), .STARVE_MAX(3)) dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .f_req(a_f_req), .f_addr(a_f_addr), .f_ack(a_f_ack), .f_done(a_f_done), .f_rdata(a_f_rdata),
    .x_req(a_x_req), .x_we(a_x_we), .x_addr(a_x_addr), .x_wdata(a_x_wdata),
    .x_ack(a_x_ack), .x_done(a_x_done), .x_rdata(a_x_rdata),
    .mem_addr(a_mem_addr), .mem_data_out(a_mem_data_out), .mem_we(a_mem_we),
    .mem_data_in(a_mem_data_in), .busy(a_busy)
  );

  mem_port_arbiter #(.RD_LAT(3), .STARVE_MAX(3)) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .f_req(b_f_req), .f_addr(b_f_addr), .f_ack(b_f_ack), .f_done(b_f_done), .f_rdata(b_f_rdata),
    .x_req(b_x_req), .x_we(b_x_we), .x_addr(b_x_addr), .x_wdata(b_x_wdata),
    .x_ack(b_x_ack), .x_done(b_x_done), .x_rdata(b_x_rdata),
    .mem_addr(b_mem_addr), .mem_data_out(b_mem_data_out), .mem_we(b_mem_we),
    .mem_data_in(b_mem_data_in), .busy(b_busy)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int kind, input int c, input logic [15:0] data);
    ev_t e;
    e.kind = kind; e.cyc = c; e.data = data;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic pop_ev(input int d, input int kind, input logic [15:0] data);
    ev_t e;
    checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      errors++;
      $display("FAIL dut%0d unexpected event kind=%0d data=%h at cycle %0d", d, kind, data, cyc);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (e.kind != kind || e.cyc != cyc || e.data !== data) begin
      errors++;
      $display("FAIL dut%0d event: got kind=%0d cyc=%0d data=%h expected kind=%0d cyc=%0d data=%h",
               d, kind, cyc, data, e.kind, e.cyc, e.data);
    end
  endtask

  // monitor: within a cycle events are consumed in the order FACK, XACK, FDONE, XDONE, WE
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_f_ack  === 1'b1) pop_ev(0, EV_FACK,  16'h0);
      if (a_x_ack  === 1'b1) pop_ev(0, EV_XACK,  16'h0);
      if (a_f_done === 1'b1) pop_ev(0, EV_FDONE, {8'h0, a_f_rdata});
      if (a_x_done === 1'b1) pop_ev(0, EV_XDONE, {8'h0, a_x_rdata});
      if (a_mem_we === 1'b1) pop_ev(0, EV_WE,    {a_mem_addr, a_mem_data_out});
      if (b_f_ack  === 1'b1) pop_ev(1, EV_FACK,  16'h0);
      if (b_x_ack  === 1'b1) pop_ev(1, EV_XACK,  16'h0);
      if (b_f_done === 1'b1) pop_ev(1, EV_FDONE, {8'h0, b_f_rdata});
      if (b_x_done === 1'b1) pop_ev(1, EV_XDONE, {8'h0, b_x_rdata});
      if (b_mem_we === 1'b1) pop_ev(1, EV_WE,    {b_mem_addr, b_mem_data_out});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int c;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5; mem[8'h30] = 8'h11; mem[8'h31] = 8'h22; mem[8'h12] = 8'hC3;
    mem[8'h05] = 8'h77; mem[8'h06] = 8'h55; mem[8'h40] = 8'h9E; mem[8'h50] = 8'h61;
    a_rst = 1; a_flush = 0; a_f_req = 0; a_x_req = 0; a_x_we = 0;
    a_f_addr = 0; a_x_addr = 0; a_x_wdata = 0;
    b_rst = 1; b_flush = 0; b_f_req = 0; b_x_req = 0; b_x_we = 0;
    b_f_addr = 0; b_x_addr = 0; b_x_wdata = 0;
    step(3);
    a_rst = 0; b_rst = 0; mon_en = 1;
    chk("a reset strobes", {10'h0, a_f_ack, a_f_done, a_x_ack, a_x_done, a_mem_we, a_busy}, 16'h0);
    chk("a reset rdata", {a_f_rdata, a_x_rdata}, 16'h0);
    chk("a reset bus", {a_mem_addr, a_mem_data_out}, 16'h0);
    chk("b reset strobes", {10'h0, b_f_ack, b_f_done, b_x_ack, b_x_done, b_mem_we, b_busy}, 16'h0);

    // fetch read 0x10, RD_LAT=1
    c = cyc; a_f_req = 1; a_f_addr = 8'h10;
    push(0, EV_FACK, c + 1, 16'h0); push(0, EV_FDONE, c + 3, 16'h00A5);
    step(); a_f_req = 0;
    chk("fetch addr c1", {8'h0, a_mem_addr}, 16'h0010);
    chk("fetch busy c1", {15'h0, a_busy}, 16'h1);
    step();
    chk("fetch addr c2", {8'h0, a_mem_addr}, 16'h0010);
    chk("fetch busy c2", {15'h0, a_busy}, 16'h1);
    step(3);

    // exec write 0x20 <- 0x3C
    c = cyc; a_x_req = 1; a_x_we = 1; a_x_addr = 8'h20; a_x_wdata = 8'h3C;
    push(0, EV_XACK, c + 1, 16'h0); push(0, EV_WE, c + 1, 16'h203C);
    push(0, EV_XDONE, c + 3, 16'h0000);
    step(); a_x_req = 0; a_x_we = 0;
    step(4);

    // contention: X,X,X,F repeating, an ack every 3 cycles
    c = cyc; a_f_req = 1; a_f_addr = 8'h31; a_x_req = 1; a_x_addr = 8'h30;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) begin
        push(0, EV_FACK, c + 1 + 3 * k, 16'h0); push(0, EV_FDONE, c + 3 + 3 * k, 16'h0022);
      end else begin
        push(0, EV_XACK, c + 1 + 3 * k, 16'h0); push(0, EV_XDONE, c + 3 + 3 * k, 16'h0011);
      end
    end
    step(23); a_f_req = 0; a_x_req = 0;
    step(3);

    // flush coinciding with f_req in IDLE blocks that cycle's grant
    c = cyc; a_f_req = 1; a_f_addr = 8'h12; a_flush = 1;
    push(0, EV_FACK, c + 2, 16'h0); push(0, EV_FDONE, c + 4, 16'h00C3);
    step(); a_flush = 0;
    step(); a_f_req = 0;
    step(4);

    // flush during ISSUE of a fetch: no f_done, f_rdata keeps 0xC3
    c = cyc; a_f_req = 1; a_f_addr = 8'h10;
    push(0, EV_FACK, c + 1, 16'h0);
    step(); a_f_req = 0; a_flush = 1;
    step(); a_flush = 0;
    step();
    chk("a flush rdata kept", {8'h0, a_f_rdata}, 16'h00C3);
    chk("a flush idle", {15'h0, a_busy}, 16'h0);
    step(2);

    // RD_LAT=3 exec read 0x40: done 5 cycles after ack, address stable
    c = cyc; b_x_req = 1; b_x_addr = 8'h40;
    push(1, EV_XACK, c + 1, 16'h0); push(1, EV_XDONE, c + 6, 16'h009E);
    step(); b_x_req = 0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("b read addr c%0d", i), {8'h0, b_mem_addr}, 16'h0040);
      step();
    end
    step(2);

    // normal fetch on b to load f_rdata = 0x55
    c = cyc; b_f_req = 1; b_f_addr = 8'h06;
    push(1, EV_FACK, c + 1, 16'h0); push(1, EV_FDONE, c + 6, 16'h0055);
    step(); b_f_req = 0;
    step(7);

    // flush in WAIT of fetch 0x05: no f_done, back in IDLE on schedule
    c = cyc; b_f_req = 1; b_f_addr = 8'h05;
    push(1, EV_FACK, c + 1, 16'h0);
    step(); b_f_req = 0;
    step(); b_flush = 1;
    step(); b_flush = 0;
    step(2);
    chk("b flush busy resp", {15'h0, b_busy}, 16'h1);
    step();
    chk("b flush busy idle", {15'h0, b_busy}, 16'h0);
    chk("b flush rdata kept", {8'h0, b_f_rdata}, 16'h0055);
    step(2);

    // reset in WAIT of fetch 0x50
    c = cyc; b_f_req = 1; b_f_addr = 8'h50;
    push(1, EV_FACK, c + 1, 16'h0);
    step(); b_f_req = 0;
    step(); b_rst = 1;
    step(); b_rst = 0;
    chk("b midrst strobes", {10'h0, b_f_ack, b_f_done, b_x_ack, b_x_done, b_mem_we, b_busy}, 16'h0);
    chk("b midrst rdata", {b_f_rdata, b_x_rdata}, 16'h0);
    chk("b midrst bus", {b_mem_addr, b_mem_data_out}, 16'h0);
    step(6);
    c = cyc; b_f_req = 1; b_f_addr = 8'h50;
    push(1, EV_FACK, c + 1, 16'h0); push(1, EV_FDONE, c + 6, 16'h0061);
    step(); b_f_req = 0;
    step(8);

    chk("a events outstanding", 16'(q0.size()), 16'h0);
    chk("b events outstanding", 16'(q1.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
